muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execute unit, directly upstream of the memory stage.
- Its result joins the ALU result on the path that becomes the memory stage's address/ALU-result input, so ResultSrc=00 selects it for writeback.
- Asserts busy so the core stalls PC and the register-file write until done.
- One operation in flight at a time; shift-add multiply and restoring divide, one bit per clock.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_datapath.sv | 100 ++++++++++
 rtl/muldiv_unit.sv | 113 +++++++++++
 tb/tb_muldiv_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 opcodes,
// FSM state encoding, default operand width and opcode helpers.
package muldiv_pkg;

   localparam int unsigned XLEN_DEF = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_CALC = S_CALC,
      ST_DONE = S_DONE
   } state_t;

   // funct3[2] separates the divide/remainder group from the multiplies
   function automatic logic is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift/accumulate datapath: latches operand magnitudes and sign flags on
// load, performs one shift-add multiply or restoring-divide bit per step,
// and presents the sign-corrected result of the step in progress.
// Ports: clk, rst (sync, active-high), load, step, funct3, rs1_val, rs2_val,
//        result_c (combinational, valid on the final step).
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic [XLEN-1:0] result_c
);

   localparam int unsigned AW = 2 * XLEN;

   logic [2:0]      op_q;
   logic [XLEN-1:0] opnd_q;
   logic [AW-1:0]   acc_q;
   logic            neg_q;
   logic            rem_neg_q;

   logic            a_signed_c, b_signed_c, a_neg_c, b_neg_c;
   logic [XLEN-1:0] mag_a_c, mag_b_c;

   // Operand conditioning: signedness per opcode, then magnitudes
   always_comb begin
      a_signed_c = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
      b_signed_c = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
      a_neg_c    = a_signed_c & rs1_val[XLEN-1];
      b_neg_c    = b_signed_c & rs2_val[XLEN-1];
      mag_a_c    = a_neg_c ? -rs1_val : rs1_val;
      mag_b_c    = b_neg_c ? -rs2_val : rs2_val;
   end

   logic [XLEN:0]   sum_c, shifted_c, diff_c;
   logic [AW-1:0]   acc_mul_c, acc_div_c, acc_nxt_c, prod_c;
   logic [XLEN-1:0] quo_c, rem_c;

   // One iteration; acc holds {hi, lo} = {partial product, multiplier} or {remainder, quotient}
   always_comb begin
      sum_c     = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      acc_mul_c = {sum_c, acc_q[XLEN-1:1]};

      shifted_c = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
      diff_c    = shifted_c - {1'b0, opnd_q};
      if (!diff_c[XLEN]) begin
         acc_div_c = {diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_div_c = {shifted_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end

      acc_nxt_c = is_div(op_q) ? acc_div_c : acc_mul_c;
      prod_c    = neg_q ? -acc_nxt_c : acc_nxt_c;
      quo_c     = neg_q ? -acc_nxt_c[XLEN-1:0] : acc_nxt_c[XLEN-1:0];
      rem_c     = rem_neg_q ? -acc_nxt_c[AW-1:XLEN] : acc_nxt_c[AW-1:XLEN];

      result_c = '0;
      case (op_q)
         F3_MUL:                      result_c = prod_c[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: result_c = prod_c[AW-1:XLEN];
         F3_DIV, F3_DIVU:             result_c = quo_c;
         default:                     result_c = rem_c;
      endcase
   end

   // Operand/flag latch on load, accumulator update per step
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= '0;
         opnd_q    <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
      end else if (load) begin
         op_q      <= funct3;
         neg_q     <= a_neg_c ^ b_neg_c;
         rem_neg_q <= a_neg_c;
         if (is_div(funct3)) begin
            opnd_q <= mag_b_c;
            acc_q  <= {{XLEN{1'b0}}, mag_a_c};
         end else begin
            opnd_q <= mag_a_c;
            acc_q  <= {{XLEN{1'b0}}, mag_b_c};
         end
      end else if (step) begin
         acc_q <= acc_nxt_c;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit. One operation at a time,
// one bit per clock; busy stalls the core, done pulses with the result.
// Divide-by-zero and signed overflow complete immediately without CALC.
// Ports: clk, rst (sync, active-high), start, funct3, rs1_val, rs2_val,
//        flush, busy, done, result (registered, held until next done/reset).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned   CNT_W   = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state;
   logic [CNT_W-1:0]  counter;

   logic              div_zero_c, div_ovf_c, special_c;
   logic              load_c, step_c, last_c;
   logic [XLEN-1:0]   special_res_c, dp_result_c;

   // Special-case detection and immediate results
   always_comb begin
      div_zero_c    = is_div(funct3) && (rs2_val == '0);
      div_ovf_c     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (rs1_val == MIN_NEG) && (rs2_val == '1);
      special_c     = div_zero_c || div_ovf_c;
      special_res_c = '0;
      if (div_zero_c) begin
         special_res_c = ((funct3 == F3_DIV) || (funct3 == F3_DIVU)) ? '1 : rs1_val;
      end else if (div_ovf_c) begin
         special_res_c = (funct3 == F3_DIV) ? rs1_val : '0;
      end
      load_c = (state == ST_IDLE) && start && !flush && !special_c;
      step_c = (state == ST_CALC) && !flush;
      last_c = (counter == CNT_W'(XLEN - 1));
   end

   muldiv_datapath #(.XLEN(XLEN)) u_datapath (
      .clk      (clk),
      .rst      (rst),
      .load     (load_c),
      .step     (step_c),
      .funct3   (funct3),
      .rs1_val  (rs1_val),
      .rs2_val  (rs2_val),
      .result_c (dp_result_c)
   );

   // Control FSM with registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         counter <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start && !flush) begin
                  if (special_c) begin
                     result <= special_res_c;
                     done   <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     busy    <= 1'b1;
                     counter <= '0;
                     state   <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (flush) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  counter <= counter + CNT_W'(1);
                  if (last_c) begin
                     result <= dp_result_c;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     state  <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, reset/flush/start
// robustness, then random operations against a plain-arithmetic model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam logic [31:0] MINV = 32'h8000_0000;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1_val, rs2_val;
   logic        busy, done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .funct3  (funct3),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // RV32M semantics from wide integer arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f3)
         F3_MUL:    begin p = 64'(sa * sb);           return p[31:0];  end
         F3_MULH:   begin p = 64'(sa * sb);           return p[63:32]; end
         F3_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
         F3_MULHU:  begin p = ua * ub;                return p[63:32]; end
         F3_DIV: begin
            if (b == 32'd0) return ONES;
            if (a == MINV && b == ONES) return a;
            return 32'(sa / sb);
         end
         F3_REM: begin
            if (b == 32'd0) return a;
            if (a == MINV && b == ONES) return 32'd0;
            return 32'(sa % sb);
         end
         F3_DIVU: begin
            if (b == 32'd0) return ONES;
            return 32'(ua / ub);
         end
         default: begin
            if (b == 32'd0) return a;
            return 32'(ua % ub);
         end
      endcase
   endfunction

   // Called #1 after an edge with the unit idle; that cycle is cycle 0
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int          done_cyc, busy_cnt, busy_first;
      logic        spec;
      logic [31:0] got;
      spec = (f3[2] && b == 32'd0) ||
             ((f3 == F3_DIV || f3 == F3_REM) && a == MINV && b == ONES);
      funct3 = f3; rs1_val = a; rs2_val = b; start = 1'b1;
      done_cyc = -1; busy_cnt = 0; busy_first = -1; got = 'x;
      for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
         @(posedge clk); #1;
         if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = cyc;
         end
         if (done) begin
            done_cyc = cyc;
            got      = result;
            start    = 1'b0;
         end
      end
      start = 1'b0;
      check({tag, "_done_cycle"}, 32'(done_cyc), spec ? 32'd1 : 32'd33);
      check({tag, "_busy_cycles"}, 32'(busy_cnt), spec ? 32'd0 : 32'd32);
      check({tag, "_busy_first"}, 32'(busy_first), spec ? ONES : 32'd1);
      check({tag, "_result"}, got, exp);
      @(posedge clk); #1;
      check({tag, "_done_single"}, {31'b0, done}, 32'd0);
      check({tag, "_result_hold"}, result, exp);
   endtask

   initial begin
      int          dcnt, dcyc;
      logic [31:0] dres, exp2, a, b;
      logic [2:0]  f3;

      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("mul_neg",   F3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
      run_op("mulhu_max", F3_MULHU,  ONES,         ONES,          32'hFFFF_FFFE);
      run_op("mulh_m1",   F3_MULH,   ONES,         ONES,          32'h0000_0000);
      run_op("mulhsu",    F3_MULHSU, ONES,         32'd2,         32'hFFFF_FFFF);
      run_op("div_neg",   F3_DIV,    32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA);
      run_op("rem_neg",   F3_REM,    32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE);
      run_op("divu",      F3_DIVU,   32'd100,      32'd7,         32'd14);
      run_op("remu",      F3_REMU,   32'd100,      32'd7,         32'd2);
      run_op("divu_z",    F3_DIVU,   32'd100,      32'd0,         ONES);
      run_op("remu_z",    F3_REMU,   32'd100,      32'd0,         32'h0000_0064);
      run_op("div_ovf",   F3_DIV,    MINV,         ONES,          MINV);
      run_op("rem_ovf",   F3_REM,    MINV,         ONES,          32'd0);

      // Reset in the middle of a divide
      funct3 = F3_DIV; rs1_val = 32'd1000; rs2_val = 32'd7; start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 9) check("rstmid_busy_before", {31'b0, busy}, 32'd1);
      end
      rst = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstmid_busy", {31'b0, busy}, 32'd0);
      check("rstmid_done", {31'b0, done}, 32'd0);
      check("rstmid_result", result, 32'd0);
      run_op("mul_after_rst", F3_MUL, 32'd3, 32'd4, 32'd12);

      // Flush mid-multiply: no done, result untouched
      funct3 = F3_MUL; rs1_val = 32'd5; rs2_val = 32'd6; start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
      end
      check("flush_busy_before", {31'b0, busy}, 32'd1);
      flush = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 32'd0);
      check("flush_done", {31'b0, done}, 32'd0);
      dcnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) dcnt++;
      end
      check("flush_no_done", 32'(dcnt), 32'd0);
      check("flush_result_kept", result, 32'd12);

      // Start toggling and operand churn during CALC are ignored
      a = 32'h1234_5678; b = 32'h9ABC_DEF0;
      exp2 = ref_model(F3_MULHU, a, b);
      funct3 = F3_MULHU; rs1_val = a; rs2_val = b; start = 1'b1;
      dcnt = 0; dcyc = -1; dres = 'x;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk); #1;
         if (done) begin
            dcnt++;
            if (dcyc < 0) begin dcyc = c; dres = result; end
            start = 1'b0;
         end else if (c >= 6 && c <= 20) begin
            start   = c[0];
            rs1_val = $urandom;
            funct3  = 3'($urandom_range(0, 7));
         end else if (c > 20 && dcnt == 0) begin
            start = 1'b1;
         end
      end
      start = 1'b0;
      check("toggle_done_count", 32'(dcnt), 32'd1);
      check("toggle_done_cycle", 32'(dcyc), 32'd33);
      check("toggle_result", dres, exp2);

      // Random operations, with forced zero divisors and overflow operands
      for (int i = 0; i < 24; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if (i % 4 == 3) b = {16'b0, b[15:0]};
         if (i % 6 == 0) b = 32'd0;
         if (i % 8 == 1) begin a = MINV; b = ONES; end
         run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, ref_model(f3, a, b));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
